// File: rtl/panda_risc_v_test_mon_pkg.sv
// Shared types and constants for the RISC-V test-completion monitor.
package panda_risc_v_test_mon_pkg;

  // Monitor life cycle: wait for start, watch the core, let the result settle, report.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SETTLE,
    ST_DONE,
    ST_TMO
  } mon_state_e;

  // Register indices used by the riscv-tests end-of-test convention.
  localparam logic [4:0] REG_TESTNUM = 5'd3;   // gp: current test number
  localparam logic [4:0] REG_END     = 5'd26;  // s10: written with 1 at end of test
  localparam logic [4:0] REG_RESULT  = 5'd27;  // s11: 1 means pass

endpackage

// File: rtl/panda_risc_v_test_mon_shadow.sv
// Three-entry shadow of x3, x26 and x27, snooped from the EXU writeback port.
// end_hit flags, in the same cycle as the strobe, a write of exactly 1 to x26.
module panda_risc_v_test_mon_shadow
  import panda_risc_v_test_mon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        rf_wen,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdat,
  output logic [31:0] testnum,
  output logic [31:0] result,
  output logic        end_hit
);

  logic        wr_testnum;
  logic        wr_end;
  logic        wr_result;
  logic [31:0] end_q;
  logic [31:0] end_nxt;

  // Decode which shadow, if any, the current writeback targets; x0 and others fall through.
  always_comb begin
    wr_testnum = rf_wen && (rf_waddr == REG_TESTNUM);
    wr_end     = rf_wen && (rf_waddr == REG_END);
    wr_result  = rf_wen && (rf_waddr == REG_RESULT);
    end_nxt    = wr_end ? rf_wdat : end_q;
    end_hit    = wr_end && (end_nxt == 32'h1);
  end

  // Shadow registers: cleared by reset or restart, otherwise follow matching writes.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      testnum <= '0;
      end_q   <= '0;
      result  <= '0;
    end else if (clr) begin
      testnum <= '0;
      end_q   <= '0;
      result  <= '0;
    end else begin
      if (wr_testnum) testnum <= rf_wdat;
      if (wr_result)  result  <= rf_wdat;
      end_q <= end_nxt;
    end
  end

endmodule

// File: rtl/panda_risc_v_test_mon.sv
// Test-completion monitor: watches register writeback for the end-of-test marker,
// waits for the result to settle, then latches pass/fail or a timeout.
// Optional feature macro: PANDA_TEST_MON_CYCLE_CNT_EN builds the run_cycles counter.
module panda_risc_v_test_mon
  import panda_risc_v_test_mon_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES    = 10,
  parameter int unsigned TIMEOUT_CYCLES   = 1000000,
  parameter int          simulation_delay = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mon_en,
  input  logic        mon_clr,
  input  logic        rf_wen,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdat,
  output logic        test_done,
  output logic        test_pass,
  output logic        test_timeout,
  output logic [31:0] fail_testnum,
  output logic [31:0] run_cycles
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [31:0] RUN_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          TMO_EN      = (TIMEOUT_CYCLES != 0);

  // Register update delays are a simulation-only notion; the synthesizable model has none.
  if (simulation_delay < 0) begin : g_neg_delay
  end

  mon_state_e  state;
  mon_state_e  state_nxt;
  logic [31:0] run_cnt;
  logic [15:0] settle_cnt;
  logic [31:0] sh_testnum;
  logic [31:0] sh_result;
  logic        end_hit;

  panda_risc_v_test_mon_shadow u_shadow (
    .clk      (clk),
    .rst      (rst),
    .clr      (mon_clr),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdat  (rf_wdat),
    .testnum  (sh_testnum),
    .result   (sh_result),
    .end_hit  (end_hit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the end marker beats the timeout, and restart beats everything.
  // NOTE: state_nxt gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (mon_en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (end_hit)                             state_nxt = ST_SETTLE;
        else if (TMO_EN && (run_cnt == RUN_LAST)) state_nxt = ST_TMO;
      end
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_DONE;
      ST_TMO:    state_nxt = ST_TMO;
      default:   state_nxt = ST_IDLE;
    endcase
    if (mon_clr) state_nxt = ST_IDLE;
  end

  // Phase counters and result latches; results are written only on entry to DONE/TMO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt      <= '0;
      settle_cnt   <= '0;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
      test_timeout <= 1'b0;
      fail_testnum <= '0;
    end else if (mon_clr) begin
      run_cnt      <= '0;
      settle_cnt   <= '0;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
      test_timeout <= 1'b0;
      fail_testnum <= '0;
    end else begin
      if ((state == ST_RUN) && (state_nxt == ST_RUN))
        run_cnt <= (run_cnt != '1) ? run_cnt + 32'd1 : run_cnt;
      else
        run_cnt <= '0;

      if ((state == ST_SETTLE) && (state_nxt == ST_SETTLE))
        settle_cnt <= settle_cnt + 16'd1;
      else
        settle_cnt <= '0;

      if ((state == ST_SETTLE) && (state_nxt == ST_DONE)) begin
        test_done    <= 1'b1;
        test_pass    <= (sh_result == 32'h1);
        fail_testnum <= sh_testnum;
      end

      if ((state == ST_RUN) && (state_nxt == ST_TMO)) begin
        test_done    <= 1'b1;
        test_timeout <= 1'b1;
        test_pass    <= 1'b0;
        fail_testnum <= sh_testnum;
      end
    end
  end

`ifdef PANDA_TEST_MON_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  // Saturating count of cycles spent in RUN or SETTLE; frozen once the result is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cycle_cnt <= '0;
    else if (mon_clr)
      cycle_cnt <= '0;
    else if (((state == ST_RUN) || (state == ST_SETTLE)) && (cycle_cnt != '1))
      cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign run_cycles = cycle_cnt;
`else
  assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_panda_risc_v_test_mon.sv
// Self-checking bench for panda_risc_v_test_mon (SETTLE_CYCLES=10, TIMEOUT_CYCLES=50).
// Honours PANDA_TEST_MON_CYCLE_CNT_EN when expecting run_cycles.
module tb_panda_risc_v_test_mon;

  localparam int unsigned SETTLE  = 10;
  localparam int unsigned TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mon_en = 1'b0;
  logic        mon_clr = 1'b0;
  logic        rf_wen = 1'b0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdat = '0;
  logic        test_done;
  logic        test_pass;
  logic        test_timeout;
  logic [31:0] fail_testnum;
  logic [31:0] run_cycles;

  int checks = 0;
  int failures = 0;

  panda_risc_v_test_mon #(
    .SETTLE_CYCLES    (SETTLE),
    .TIMEOUT_CYCLES   (TIMEOUT),
    .simulation_delay (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mon_en       (mon_en),
    .mon_clr      (mon_clr),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdat      (rf_wdat),
    .test_done    (test_done),
    .test_pass    (test_pass),
    .test_timeout (test_timeout),
    .fail_testnum (fail_testnum),
    .run_cycles   (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks how long the test has been running / settling as plain integers and
  // derives the reported outcome from the end-of-test rules.
  bit          m_running, m_settling, m_finished;
  int unsigned m_run_age, m_settle_age;
  logic [31:0] m_x3, m_x26, m_x27;
  bit          exp_done, exp_pass, exp_tmo;
  logic [31:0] exp_fnum, exp_cycles;

  task automatic model_clear();
    m_running = 0; m_settling = 0; m_finished = 0;
    m_run_age = 0; m_settle_age = 0;
    m_x3 = 0; m_x26 = 0; m_x27 = 0;
    exp_done = 0; exp_pass = 0; exp_tmo = 0; exp_fnum = 0; exp_cycles = 0;
  endtask

  initial model_clear();

  always @(posedge clk or posedge rst) begin
    if (rst || mon_clr) begin
      model_clear();
    end else begin
      bit end_mark;
      end_mark = rf_wen && (rf_waddr == 5'd26) && (rf_wdat == 32'd1);
`ifdef PANDA_TEST_MON_CYCLE_CNT_EN
      if ((m_running || m_settling) && exp_cycles != 32'hFFFF_FFFF) exp_cycles = exp_cycles + 1;
`endif
      if (m_settling) begin
        m_settle_age++;
        if (m_settle_age == SETTLE) begin
          m_settling = 0; m_finished = 1;
          exp_done = 1; exp_pass = (m_x27 == 1); exp_fnum = m_x3;
        end
      end else if (m_running) begin
        m_run_age++;
        if (end_mark) begin
          m_running = 0; m_settling = 1; m_settle_age = 0;
        end else if (TIMEOUT != 0 && m_run_age == TIMEOUT) begin
          m_running = 0; m_finished = 1;
          exp_done = 1; exp_tmo = 1; exp_pass = 0; exp_fnum = m_x3;
        end
      end else if (!m_finished && mon_en) begin
        m_running = 1; m_run_age = 0;
      end
      if (rf_wen && rf_waddr == 5'd3)  m_x3  = rf_wdat;
      if (rf_wen && rf_waddr == 5'd26) m_x26 = rf_wdat;
      if (rf_wen && rf_waddr == 5'd27) m_x27 = rf_wdat;
    end
  end

  // Compare DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("mdl_done", {31'd0, test_done}, {31'd0, exp_done});
    check("mdl_pass", {31'd0, test_pass}, {31'd0, exp_pass});
    check("mdl_tmo", {31'd0, test_timeout}, {31'd0, exp_tmo});
    check("mdl_fnum", fail_testnum, exp_fnum);
    check("mdl_cycles", run_cycles, exp_cycles);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rf_wen = 1'b1; rf_waddr = a; rf_wdat = d;
    step();
    rf_wen = 1'b0; rf_waddr = '0; rf_wdat = '0;
  endtask

  task automatic pulse_clr();
    mon_clr = 1'b1; step(); mon_clr = 1'b0;
  endtask

  task automatic start();
    mon_en = 1'b1; step(); mon_en = 1'b0;
  endtask

  // Waits for test_done; lat returns the number of edges taken (already 'start' edges done).
  task automatic wait_done(input string name, input int start_lat, input int limit, output int lat);
    lat = start_lat;
    while (!test_done && lat < limit) begin
      step();
      lat++;
    end
    if (!test_done) check({name, "_no_done"}, {31'd0, test_done}, 32'd1);
  endtask

  int lat;

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_done", {31'd0, test_done}, 32'd0);
    check("rst_fnum", fail_testnum, 32'd0);
    rst = 1'b0;
    step();

    // Pass case: done exactly SETTLE+1 cycles after the x26 strobe is presented
    start();
    wr(5'd27, 32'd1);
    rf_wen = 1'b1; rf_waddr = 5'd26; rf_wdat = 32'd1;
    step();
    rf_wen = 1'b0; rf_waddr = '0; rf_wdat = '0;
    wait_done("pass", 1, 40, lat);
    check("pass_latency", lat, SETTLE + 1);
    check("pass_pass", {31'd0, test_pass}, 32'd1);
    check("pass_tmo", {31'd0, test_timeout}, 32'd0);
`ifdef PANDA_TEST_MON_CYCLE_CNT_EN
    check("pass_cycles", run_cycles, 32'd12);
`else
    check("pass_cycles", run_cycles, 32'd0);
`endif

    // Fail case
    pulse_clr();
    start();
    wr(5'd3, 32'd7);
    wr(5'd27, 32'd0);
    wr(5'd26, 32'd1);
    wait_done("fail", 0, 40, lat);
    check("fail_pass", {31'd0, test_pass}, 32'd0);
    check("fail_fnum", fail_testnum, 32'd7);

    // Late result: x27 written 3 cycles after the marker still counts
    pulse_clr();
    start();
    wr(5'd26, 32'd1);
    step(); step();
    wr(5'd27, 32'd1);
    wait_done("late", 0, 40, lat);
    check("late_pass", {31'd0, test_pass}, 32'd1);

    // Ignored writes keep RUN; then mon_clr in DONE clears everything
    pulse_clr();
    start();
    wr(5'd26, 32'd2);
    wr(5'd0, 32'd1);
    wr(5'd26, 32'd0);
    repeat (5) step();
    check("ign_done", {31'd0, test_done}, 32'd0);
    wr(5'd26, 32'd1);
    wait_done("ign", 0, 40, lat);
    check("ign_pass", {31'd0, test_pass}, 32'd0);
    pulse_clr();
    check("clr_done", {31'd0, test_done}, 32'd0);
    check("clr_cycles", run_cycles, 32'd0);
    // Idle without mon_en: a marker must not start anything
    wr(5'd26, 32'd1);
    repeat (SETTLE + 5) step();
    check("idle_hold", {31'd0, test_done}, 32'd0);

    // Timeout after exactly 50 RUN cycles; later writes do not alter latched outputs
    pulse_clr();
    start();
    wr(5'd3, 32'd9);
    wait_done("tmo", 1, 80, lat);
    check("tmo_latency", lat, TIMEOUT);
    check("tmo_flag", {31'd0, test_timeout}, 32'd1);
    check("tmo_pass", {31'd0, test_pass}, 32'd0);
    check("tmo_fnum", fail_testnum, 32'd9);
    wr(5'd3, 32'd5);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    step();
    check("tmo_frozen_fnum", fail_testnum, 32'd9);
    check("tmo_frozen_pass", {31'd0, test_pass}, 32'd0);

    // Marker on the 50th RUN cycle beats the timeout
    pulse_clr();
    start();
    repeat (TIMEOUT - 1) step();
    wr(5'd26, 32'd1);
    check("race_no_tmo", {31'd0, test_timeout}, 32'd0);
    wait_done("race", 0, 40, lat);
    check("race_tmo", {31'd0, test_timeout}, 32'd0);
    check("race_done", {31'd0, test_done}, 32'd1);

    // Reset two cycles into SETTLE discards the result and waits for mon_en
    pulse_clr();
    start();
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    step(); step();
    rst = 1'b1;
    #1;
    check("rst_mid_done", {31'd0, test_done}, 32'd0);
    check("rst_mid_cycles", run_cycles, 32'd0);
    step();
    rst = 1'b0;
    repeat (SETTLE + 5) step();
    check("rst_idle", {31'd0, test_done}, 32'd0);
    start();
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    wait_done("rst_rerun", 0, 40, lat);
    check("rst_rerun_pass", {31'd0, test_pass}, 32'd1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/panda_risc_v_test_mon.md
PANDA_RISC_V_TEST_MON -- requirements
Module: panda_risc_v_test_mon

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 10: cycles waited after the end-of-test marker before the result is sampled (legal range 1..65535).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum RUN cycles before a forced timeout; 0 disables the timeout.
REQ-003 SHALL have parameter simulation_delay, default 1: delay applied to all register updates (simulation only).
REQ-004 SHALL have ports: clk  input  1  core clock.
REQ-005 SHALL have ports: rst  input  1  asynchronous reset, active-high.
REQ-006 SHALL have ports: mon_en  input  1  start monitoring.
REQ-007 SHALL have ports: mon_clr  input  1  synchronous restart to IDLE.
REQ-008 SHALL have ports: rf_wen  input  1  register-file write strobe (EXU writeback).
REQ-009 SHALL have ports: rf_waddr  input  5  write register index.
REQ-010 SHALL have ports: rf_wdat  input  32  write data.
REQ-011 SHALL have ports: test_done  output  1  result valid, sticky.
REQ-012 SHALL have ports: test_pass  output  1  pass flag, valid when test_done=1.
REQ-013 SHALL have ports: test_timeout  output  1  timeout occurred, sticky.
REQ-014 SHALL have ports: fail_testnum  output  32  x3 value captured at sample time.
REQ-015 SHALL have ports: run_cycles  output  32  RUN+SETTLE cycle count.

Function
REQ-016 SHALL keep shadows of x3, x26 and x27, updated in the cycle after rf_wen=1 with rf_waddr equal to 3, 26 or 27; all other indices, including x0, SHALL be ignored.
REQ-017 SHALL implement FSM states IDLE, RUN, SETTLE, DONE and TMO.
- IDLE -> RUN when mon_en=1.
- RUN -> SETTLE on a write of exactly 32'h1 to x26.
- SETTLE -> DONE after SETTLE_CYCLES cycles in SETTLE.
- RUN -> TMO when the RUN counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0).
- DONE and TMO are absorbing until mon_clr or rst.
REQ-018 On entry to DONE, SHALL register test_pass = (x27 shadow == 1), using the shadow value as updated during SETTLE, and fail_testnum = x3 shadow; test_done SHALL rise in the same cycle.
REQ-019 On entry to TMO, SHALL set test_done=1, test_timeout=1, test_pass=0 and fail_testnum = x3 shadow.
REQ-020 A write of any value other than 1 to x26 SHALL update the shadow only and SHALL cause no state change.
REQ-021 If the x26 end marker and the timeout limit occur in the same cycle, the end marker SHALL win (-> SETTLE).
REQ-022 Writes arriving in DONE or TMO SHALL update the shadows but SHALL NOT alter any latched output.
REQ-023 mon_clr SHALL take priority over all transitions: next state IDLE, shadows, counters and outputs cleared.
REQ-024 The RUN timeout counter SHALL be 32 bits, saturating, and cleared on leaving RUN; the settle counter SHALL be 16 bits.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE and clear all shadows, counters, test_done, test_pass, test_timeout, fail_testnum and run_cycles to 0.
REQ-026 rst asserted mid-SETTLE SHALL discard the pending result; after release the block SHALL wait in IDLE for mon_en.

Configuration
REQ-027 Macro PANDA_TEST_MON_CYCLE_CNT_EN:
- when defined: run_cycles counts +1 per cycle in RUN or SETTLE, saturating at 32'hFFFF_FFFF and frozen in DONE/TMO;
- when undefined: run_cycles is tied to 0 and its counter is not built.

Structure
REQ-028 Package panda_risc_v_test_mon_pkg SHALL hold the FSM state enum and the constants REG_TESTNUM=3, REG_END=26 and REG_RESULT=27.
REQ-029 SHALL contain one sub-module, panda_risc_v_test_mon_shadow (three-entry write-snooping shadow register bank); the FSM and counters SHALL stay in the top module.

Verification
REQ-030 Pass case: mon_en=1; write x27=1, then x26=1 -> test_done=1 exactly SETTLE_CYCLES+1 cycles after the x26 write strobe; test_pass=1; test_timeout=0.
REQ-031 Fail case: write x3=7, x27=0, then x26=1 -> test_done=1, test_pass=0, fail_testnum=7.
REQ-032 Late result: x26=1 first, x27=1 written 3 cycles later with SETTLE_CYCLES=10 -> test_pass=1.
REQ-033 Timeout: TIMEOUT_CYCLES=50, no x26 write -> test_timeout=1 and test_done=1 after 50 RUN cycles; x26=1 arriving at cycle 50 -> SETTLE instead.
REQ-034 Ignored writes: x26=2 and rf_waddr=0 writes -> state stays RUN; mon_clr in DONE -> all outputs 0, state IDLE.
REQ-035 Reset mid-SETTLE: rst pulsed 2 cycles after x26=1 -> outputs 0, state IDLE; with the macro defined, run_cycles equals the RUN+SETTLE count in the pass case.
